// File: rtl/stream_resize_pkg.sv
// Shared items for the stream width converters (downsizer and upsizer).
//   rs_state_e     : buffer state, EMPTY (nothing pending) or SEND (lanes pending)
//   lane_idx_width : width of a lane index for a given lane count (at least 1)
//   contig_mask    : mask with lanes 0..n-1 set, i.e. a contiguous keep of n lanes
package stream_resize_pkg;

  // Widest lane count the shared mask helper supports.
  localparam int unsigned MaxLanes = 64;

  typedef enum logic {StEmpty, StSend} rs_state_e;

  function automatic int unsigned lane_idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic logic [MaxLanes-1:0] contig_mask(input int unsigned n);
    logic [MaxLanes-1:0] mask;
    for (int unsigned i = 0; i < MaxLanes; i++) begin
      mask[i] = (i < n);
    end
    return mask;
  endfunction

endpackage

// File: rtl/stream_lane_pick.sv
// Lowest-set-bit search over a lane mask.
//   mask_i  : lane mask to search
//   idx_o   : index of the lowest set lane (0 when none is set)
//   found_o : high when any lane in mask_i is set
module stream_lane_pick
  import stream_resize_pkg::*;
#(
  parameter int unsigned Width    = 4,
  parameter int unsigned IdxWidth = lane_idx_width(Width)
) (
  input  logic [Width-1:0]    mask_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                found_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = IdxWidth'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: splits each accepted wide word into its kept
// lanes and sends them one per narrow handshake, lane 0 first.
//   clk, rst_n          : clock, synchronous active-low reset
//   s_data_i/keep/last  : wide word, per-lane keep mask, packet end
//   s_valid_i/s_ready_o : wide-side handshake
//   m_data_o/m_last_o   : narrow beat and packet end (last kept lane of a last word)
//   m_valid_o/m_ready_i : narrow-side handshake
// Build option STREAM_DOWNSIZE_SPARSE_KEEP_EN: accept non-contiguous keep masks and
// skip unkept lanes. Without it keep must be contiguous from lane 0.
module stream_downsize
  import stream_resize_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH  = 1,
  parameter int unsigned T_DATA_RATIO  = 2,
  parameter int unsigned T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  rs_state_e state_q, state_d;

  logic [T_DATA_WIDTH-1:0]  data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0]  keep_q, keep_d;
  logic                     last_q, last_d;
  logic [T_WIDTH_RATIO-1:0] lane;
  logic                     final_lane;
  logic                     s_hs, m_hs;

  assign s_hs = s_valid_i & s_ready_o;
  assign m_hs = m_valid_o & m_ready_i;

`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
  // keep_q holds the lanes still to send; sent lanes are cleared.
  logic                    found;
  logic [T_DATA_RATIO-1:0] lane_bit;

  stream_lane_pick #(
    .Width    (T_DATA_RATIO),
    .IdxWidth (T_WIDTH_RATIO)
  ) u_lane_pick (
    .mask_i  (keep_q),
    .idx_o   (lane),
    .found_o (found)
  );

  assign lane_bit   = T_DATA_RATIO'(1) << lane;
  assign final_lane = found & ((keep_q & ~lane_bit) == '0);
`else
  // keep_q holds the word's keep; lane_q walks up until no kept lane remains above it.
  logic [T_WIDTH_RATIO-1:0] lane_q, lane_d;
  logic [T_DATA_RATIO-1:0]  upto_mask;

  assign lane       = lane_q;
  assign upto_mask  = T_DATA_RATIO'(contig_mask(32'(lane_q) + 32'd1));
  assign final_lane = (keep_q & ~upto_mask) == '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  always_comb begin
    lane_d = lane_q;
    if (s_hs) begin
      lane_d = '0;
    end else if (m_hs && !final_lane) begin
      lane_d = lane_q + T_WIDTH_RATIO'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. An all-zero keep word is consumed without entering SEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: begin
        if (s_hs && (s_keep_i != '0)) state_d = StSend;
      end
      StSend: begin
        if (m_hs && final_lane) begin
          state_d = (s_hs && (s_keep_i != '0)) ? StSend : StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Outputs. A new word is taken in the same cycle the final lane leaves.
  always_comb begin
    m_valid_o = (state_q == StSend);
    s_ready_o = (state_q == StEmpty) | (m_hs & final_lane);
    m_last_o  = m_valid_o & last_q & final_lane;
    m_data_o  = data_q[lane];
  end

  // Buffered keep/last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      keep_q <= keep_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    keep_d = keep_q;
    last_d = last_q;
    if (s_hs) begin
      keep_d = s_keep_i;
      last_d = s_last_i;
    end else if (m_hs && final_lane) begin
      keep_d = '0;
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
    end else if (m_hs) begin
      keep_d = keep_q & ~lane_bit;
`endif
    end
  end

  // Data buffer is not reset; it is only read while state is SEND.
  always_ff @(posedge clk) begin
    if (s_hs) begin
      data_q <= s_data_i;
    end
  end

endmodule
